// File: rtl/vec_dot_mac_param.sv
// Multi-lane fixed-point dot-product engine: LANES products per beat are
// accumulated over len beats; the result is rescaled by FRAC_W and saturated.
// Ports: clk, rst (async, active-high); start/len job control;
//   in_valid/in_ready with vec_a/vec_b packed operand beats;
//   out_valid/out_ready with dot_out/overflow result; busy (not idle).
module vec_dot_mac_param #(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 14,
   parameter int LANES  = 4,
   parameter int LEN_W  = 10,
   parameter int ACC_W  = 2*DATA_W + $clog2(LANES) + LEN_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [LEN_W-1:0]          len,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LANES*DATA_W-1:0]   vec_a,
   input  logic [LANES*DATA_W-1:0]   vec_b,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_W-1:0]         dot_out,
   output logic                      overflow,
   output logic                      busy
);

   localparam int PW      = 2*DATA_W;
   localparam int ACC_MIN = 2*DATA_W + $clog2(LANES) + LEN_W;

   // Wrap-free accumulation depends on this lower bound.
   if (ACC_W < ACC_MIN) begin : g_acc_chk
      $error("ACC_W too small for wrap-free accumulation");
   end

   localparam logic signed [ACC_W-1:0] MAXV =
      {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] MINV =
      {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

   state_t state, state_nx;

   logic [LEN_W-1:0]        len_q;
   logic [LEN_W-1:0]        cnt;
   logic signed [PW-1:0]    prod_d [LANES];
   logic signed [PW-1:0]    prod_q [LANES];
   logic                    pvalid;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] lane_sum;
   logic signed [ACC_W-1:0] acc_nx;
   logic signed [ACC_W-1:0] res;
   logic                    accept;
   logic                    last_beat;
   logic                    sat_hi;
   logic                    sat_lo;

   assign accept    = in_valid && (state == ACCUM);
   assign last_beat = in_valid && ((cnt + 1'b1) == len_q);

   always_comb begin
      lane_sum = '0;
      for (int i = 0; i < LANES; i++) begin
         prod_d[i] = PW'($signed(vec_a[i*DATA_W +: DATA_W]))
                   * PW'($signed(vec_b[i*DATA_W +: DATA_W]));
         lane_sum  = lane_sum + ACC_W'(prod_q[i]);
      end
   end

   // Post-add value: the DRAIN result sees the last beat's products.
   always_comb begin
      acc_nx = pvalid ? (acc + lane_sum) : acc;
      res    = acc_nx >>> FRAC_W;
      sat_hi = (res > MAXV);
      sat_lo = (res < MINV);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = (state != IDLE);
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nx = (len == '0) ? DRAIN : ACCUM;
            end
         end
         ACCUM: begin
            in_ready = 1'b1;
            if (last_beat) begin
               state_nx = DRAIN;
            end
         end
         DRAIN: begin
            state_nx = OUT;
         end
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_q    <= '0;
         cnt      <= '0;
         pvalid   <= 1'b0;
         acc      <= '0;
         dot_out  <= '0;
         overflow <= 1'b0;
         for (int i = 0; i < LANES; i++) begin
            prod_q[i] <= '0;
         end
      end else begin
         pvalid <= accept;
         if (accept) begin
            for (int i = 0; i < LANES; i++) begin
               prod_q[i] <= prod_d[i];
            end
         end
         if (state == IDLE && start) begin
            acc   <= '0;
            cnt   <= '0;
            len_q <= len;
         end else begin
            acc <= acc_nx;
            if (accept) begin
               cnt <= cnt + 1'b1;
            end
         end
         if (state == DRAIN) begin
            overflow <= sat_hi | sat_lo;
            if (sat_hi) begin
               dot_out <= {1'b0, {(DATA_W-1){1'b1}}};
            end else if (sat_lo) begin
               dot_out <= {1'b1, {(DATA_W-1){1'b0}}};
            end else begin
               dot_out <= res[DATA_W-1:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_vec_dot_mac_param.sv
// Directed self-checking bench for vec_dot_mac_param (default parameters).
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_vec_dot_mac_param;

   logic        clk;
   logic        rst;
   logic        start;
   logic [9:0]  len;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] vec_a;
   logic [63:0] vec_b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] dot_out;
   logic        overflow;
   logic        busy;

   int total;
   int bad;

   vec_dot_mac_param dut (
      .clk(clk), .rst(rst), .start(start), .len(len),
      .in_valid(in_valid), .in_ready(in_ready),
      .vec_a(vec_a), .vec_b(vec_b),
      .out_valid(out_valid), .out_ready(out_ready),
      .dot_out(dot_out), .overflow(overflow), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_all(input logic [15:0] a, input logic [15:0] b);
      vec_a = {a, a, a, a};
      vec_b = {b, b, b, b};
   endtask

   task automatic do_start(input logic [9:0] l);
      start = 1'b1;
      len   = l;
      tick();
      start = 1'b0;
   endtask

   task automatic take_out();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0; len = '0; in_valid = 1'b0;
      out_ready = 1'b0; vec_a = '0; vec_b = '0;
      tick();
      tick();
      total++;
      if ({in_ready, out_valid, busy, overflow, dot_out} !== 19'd0) begin
         bad++;
         $display("FAIL reset outputs got=%b exp=0",
                  {in_ready, out_valid, busy, overflow, dot_out});
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      set_all(16'd16384, 16'd4096);
      do_start(10'd1);
      total++;
      if ({busy, in_ready} !== 2'b11) begin
         bad++;
         $display("FAIL basic_start busy/in_ready got=%b exp=11",
                  {busy, in_ready});
      end
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      total++;
      if ({in_ready, out_valid} !== 2'b00) begin
         bad++;
         $display("FAIL basic_k in_ready/out_valid got=%b exp=00",
                  {in_ready, out_valid});
      end
      tick();
      total++;
      if (out_valid !== 1'b1 || dot_out !== 16'd16384 || overflow !== 1'b0) begin
         bad++;
         $display("FAIL basic_result got v=%b d=%0d o=%b exp v=1 d=16384 o=0",
                  out_valid, $signed(dot_out), overflow);
      end
      take_out();
      total++;
      if ({out_valid, busy} !== 2'b00) begin
         bad++;
         $display("FAIL basic_accept out_valid/busy got=%b exp=00",
                  {out_valid, busy});
      end
   endtask

   task automatic test_saturation();
      logic [15:0] av [2];
      logic [15:0] ed [2];
      av[0] = 16'd16384;  ed[0] = 16'h7FFF;
      av[1] = 16'hC000;   ed[1] = 16'h8000;
      for (int i = 0; i < 2; i++) begin
         set_all(av[i], 16'd16384);
         do_start(10'd1);
         in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         tick();
         total++;
         if (out_valid !== 1'b1 || dot_out !== ed[i] || overflow !== 1'b1) begin
            bad++;
            $display("FAIL sat_%0d got v=%b d=%h o=%b exp v=1 d=%h o=1",
                     i, out_valid, dot_out, overflow, ed[i]);
         end
         take_out();
      end
   endtask

   task automatic test_floor();
      logic [15:0] av [2];
      logic [15:0] ed [2];
      av[0] = 16'd1;     ed[0] = 16'd0;
      av[1] = 16'hFFFF;  ed[1] = 16'hFFFF;
      for (int i = 0; i < 2; i++) begin
         vec_a = {48'd0, av[i]};
         vec_b = {48'd0, 16'd1};
         do_start(10'd1);
         in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         tick();
         total++;
         if (out_valid !== 1'b1 || dot_out !== ed[i] || overflow !== 1'b0) begin
            bad++;
            $display("FAIL floor_%0d got v=%b d=%h o=%b exp v=1 d=%h o=0",
                     i, out_valid, dot_out, overflow, ed[i]);
         end
         take_out();
      end
   endtask

   task automatic test_bubbles();
      logic [4:0] pat;
      int acc_beats;
      pat = 5'b10101;
      acc_beats = 0;
      vec_a = {48'd0, 16'd16384};
      vec_b = {48'd0, 16'd1638};
      do_start(10'd3);
      for (int i = 0; i < 5; i++) begin
         in_valid = pat[i];
         if (pat[i] && in_ready) acc_beats++;
         tick();
      end
      total++;
      if (acc_beats !== 3 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL bubbles_k beats=%0d rdy=%b v=%b exp beats=3 rdy=0 v=0",
                  acc_beats, in_ready, out_valid);
      end
      tick();
      total++;
      if (out_valid !== 1'b1 || dot_out !== 16'd4914 || overflow !== 1'b0) begin
         bad++;
         $display("FAIL bubbles_result got v=%b d=%0d o=%b exp v=1 d=4914 o=0",
                  out_valid, $signed(dot_out), overflow);
      end
      tick();
      in_valid = 1'b0;
      total++;
      if (dot_out !== 16'd4914 || in_ready !== 1'b0) begin
         bad++;
         $display("FAIL bubbles_extra got d=%0d rdy=%b exp d=4914 rdy=0",
                  $signed(dot_out), in_ready);
      end
      take_out();
   endtask

   task automatic test_backpressure();
      int held;
      held = 0;
      set_all(16'd16384, 16'd4096);
      do_start(10'd1);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         start = (i == 2);
         len   = 10'd1;
         tick();
         if (out_valid === 1'b1 && busy === 1'b1 && dot_out === 16'd16384)
            held++;
      end
      start = 1'b0;
      total++;
      if (held !== 5) begin
         bad++;
         $display("FAIL backpressure_hold got=%0d cycles exp=5", held);
      end
      take_out();
      total++;
      if ({out_valid, busy} !== 2'b00) begin
         bad++;
         $display("FAIL backpressure_accept got=%b exp=00", {out_valid, busy});
      end
      tick();
      total++;
      if ({out_valid, busy, in_ready} !== 3'b000) begin
         bad++;
         $display("FAIL backpressure_no_second_job got=%b exp=000",
                  {out_valid, busy, in_ready});
      end
   endtask

   task automatic test_reset_mid();
      set_all(16'd16384, 16'd16384);
      do_start(10'd3);
      in_valid = 1'b1;
      tick();
      tick();
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      total++;
      if ({in_ready, out_valid, busy, overflow, dot_out} !== 19'd0) begin
         bad++;
         $display("FAIL reset_mid outputs got=%b exp=0",
                  {in_ready, out_valid, busy, overflow, dot_out});
      end
      #1;
      rst = 1'b0;
      tick();
      set_all(16'd16384, 16'd4096);
      do_start(10'd1);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      total++;
      if (out_valid !== 1'b1 || dot_out !== 16'd16384 || overflow !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_next got v=%b d=%0d o=%b exp v=1 d=16384 o=0",
                  out_valid, $signed(dot_out), overflow);
      end
      take_out();
   endtask

   task automatic test_len0();
      do_start(10'd0);
      total++;
      if ({busy, in_ready, out_valid} !== 3'b100) begin
         bad++;
         $display("FAIL len0_s busy/rdy/v got=%b exp=100",
                  {busy, in_ready, out_valid});
      end
      tick();
      total++;
      if (out_valid !== 1'b1 || dot_out !== 16'd0 || overflow !== 1'b0) begin
         bad++;
         $display("FAIL len0_result got v=%b d=%0d o=%b exp v=1 d=0 o=0",
                  out_valid, $signed(dot_out), overflow);
      end
      take_out();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_basic();
      test_saturation();
      test_floor();
      test_bubbles();
      test_backpressure();
      test_reset_mid();
      test_saturation();
      test_len0();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vec_dot_mac_param.md
# vec_dot_mac_param

Parametrised multi-lane fixed-point dot-product engine. It accepts LANES element pairs per beat over a valid/ready stream and accumulates a programmable number of beats into a wide signed accumulator. It then returns one rescaled, saturated DATA_W result through an output handshake. It sits in the PE datapath between the activation/weight buffers and the neuron output register file, and replaces the single-pair, non-accumulating multiplier stage.

## Interface
- DATA_W, 16: signed element and result width.
- FRAC_W, 14: fraction bits of operands and result (1-1-14 default); the result is the accumulator arithmetically shifted right by FRAC_W.
- LANES, 4: element pairs multiplied per beat.
- LEN_W, 10: width of the beat-count field; at most 2^LEN_W-1 beats per job.
- ACC_W, 2*DATA_W+clog2(LANES)+LEN_W: accumulator width. The accumulator never wraps by construction; elaboration fails if ACC_W is smaller than this value.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  job start pulse; honoured only in IDLE.
- len  in  LEN_W  beats in the job; sampled on an honoured start.
- in_valid  in  1  beat present on vec_a/vec_b.
- in_ready  out  1  high only in ACCUM.
- vec_a  in  LANES*DATA_W  packed signed operands; lane i is [i*DATA_W +: DATA_W].
- vec_b  in  LANES*DATA_W  packed signed operands, same packing as vec_a.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- dot_out  out  DATA_W  saturated result.
- overflow  out  1  result was clamped; valid with out_valid.
- busy  out  1  state is not IDLE.

## Operation
- States: IDLE, ACCUM, DRAIN, OUT.
- IDLE, on start:
  - Clear acc and the beat counter; latch len.
  - If len=0, go to DRAIN; otherwise go to ACCUM.
- ACCUM:
  - in_ready=1. Each beat with in_valid&in_ready registers the LANES signed products (2*DATA_W each) into the product stage and sets the stage's valid bit.
  - Cycles without in_valid are bubbles; they add nothing.
  - On the len-th accepted beat, go to DRAIN.
- Product stage: on every edge where its valid bit is set, acc += sign-extended sum of all lanes.
- DRAIN (one cycle):
  - Perform the final add.
  - Register dot_out and overflow from the post-add acc value.
  - Go to OUT.
- Result rule: r = acc >>> FRAC_W, rounding toward minus infinity.
  - r > 2^(DATA_W-1)-1: dot_out = 2^(DATA_W-1)-1, overflow=1.
  - r < -2^(DATA_W-1): dot_out = -2^(DATA_W-1), overflow=1.
  - Otherwise dot_out = r[DATA_W-1:0], overflow=0.
- OUT:
  - out_valid=1; dot_out and overflow are held stable.
  - On out_valid&out_ready, go to IDLE.
  - start is ignored.
- start in ACCUM, DRAIN or OUT is ignored. in_valid outside ACCUM is ignored.

## Timing
- Reset values: in_ready=0, out_valid=0, dot_out=0, overflow=0, busy=0, state=IDLE, acc=0, product-stage valid=0.
- rst takes effect immediately in any state. Any in-flight job is discarded with no partial output. The first start is honoured on the first edge after rst deasserts.
- start honoured at edge s: busy=1 and in_ready=1 from s (for len>0).
- Last beat accepted at edge k:
  - in_ready=0 after k.
  - out_valid=1 and dot_out valid after edge k+1 (2-edge latency from the last beat).
- len=0 job, start at edge s: out_valid=1 after edge s+1, dot_out=0, overflow=0.
- Result accepted at edge t: out_valid=0 and busy=0 after t. A new start is honoured at t+1 at the earliest.
- Throughput: one beat per cycle in ACCUM. Per-job overhead is 2 cycles plus the output wait.

## Test plan
- Basic (LANES=4, len=1): all a=16384, all b=4096 -> dot_out=16384, overflow=0, out_valid 2 edges after the beat.
- Saturation, positive: all a=16384, all b=16384, len=1 -> dot_out=32767, overflow=1.
- Saturation, negative: all a=-16384, all b=16384 -> dot_out=-32768, overflow=1.
- Floor rounding: lane0 a=1, b=1, other lanes 0 -> dot_out=0. Lane0 a=-1, b=1 -> dot_out=-1.
- Multi-beat with bubbles: len=3; each beat has lane0 a=16384, b=1638, other lanes 0; in_valid toggles 1,0,1,0,1 -> exactly 3 beats accepted, dot_out=4914. in_ready=0 after the third beat; extra in_valid is ignored.
- Back-pressure: out_ready low for 5 cycles -> out_valid stays 1 and dot_out stays constant; a start pulse during OUT is ignored (busy stays 1, no second job).
- Reset mid-job: assert rst after 2 of 3 beats -> all outputs return to reset values at once. A following len=1 job with all a=16384, all b=4096 -> dot_out=16384, with no contamination from the aborted job.
- len=0: start with len=0 -> out_valid after edge s+1, dot_out=0, overflow=0.
